// File: rtl/zx_mem_pkg.sv
// Shared definitions for the Z80 memory-side blocks: FSM state type,
// SRAM geometry and the default fill value for unpopulated reads.
package zx_mem_pkg;

   localparam int          SRAM_AW      = 18;
   localparam logic [15:0] EXT_RAM_BASE = 16'h8000;
   localparam logic [7:0]  RAM_FILL     = 8'hFF;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_RD_SETUP,
      ST_RD_WAIT,
      ST_WR_SETUP,
      ST_WR_PULSE,
      ST_WR_HOLD,
      ST_RELEASE
   } ext_ram_state_t;

endpackage

// File: rtl/strobe_sync.sv
// Multi-stage flip-flop synchroniser for active-low CPU strobes.
// Every stage resets to 1 so the strobes read as inactive out of reset.
module strobe_sync #(
   parameter int STAGES = 2,
   parameter int WIDTH  = 5
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout
);

   logic [WIDTH-1:0] stage_reg [STAGES];

   // First stage samples the raw asynchronous strobes.
   always_ff @(posedge clk) begin
      if (reset) stage_reg[0] <= '1;
      else       stage_reg[0] <= din;
   end

   generate
      for (genvar gi = 1; gi < STAGES; gi++) begin : g_stage
         // Each further stage re-registers the previous one.
         always_ff @(posedge clk) begin
            if (reset) stage_reg[gi] <= '1;
            else       stage_reg[gi] <= stage_reg[gi-1];
         end
      end
   endgenerate

   assign dout = stage_reg[STAGES-1];

endmodule

// File: rtl/ext_ram_bridge.sv
// Z80 bus to asynchronous SRAM bridge for the upper 32K (8000-FFFF).
// Synchronises the CPU strobes, runs one timed SRAM read or write per
// CPU cycle and holds the last read byte for the data-bus selector.
module ext_ram_bridge #(
   parameter int ACCESS_CYCLES = 2,
   parameter int SYNC_STAGES   = 2,
   parameter int SRAM_AW       = zx_mem_pkg::SRAM_AW
) (
   input  logic               clk_vram,
   input  logic               reset,
   input  logic [15:0]        A,
   input  logic [7:0]         D_in,
   input  logic               nMREQ,
   input  logic               nIORQ,
   input  logic               nRD,
   input  logic               nWR,
   input  logic               nRFSH,
   output logic [7:0]         ram_data,
   output logic               nwait,
   output logic               busy,
   output logic [SRAM_AW-1:0] sram_addr,
   output logic [7:0]         sram_dq_out,
   output logic               sram_dq_oe,
   input  logic [7:0]         sram_dq_in,
   output logic               sram_ce_n,
   output logic               sram_oe_n,
   output logic               sram_we_n,
   output logic               sram_lb_n,
   output logic               sram_ub_n
);
   import zx_mem_pkg::*;

   localparam logic [3:0] CNT_LOAD = 4'(ACCESS_CYCLES - 1);

   ext_ram_state_t state_reg;
   logic [3:0]     cnt_reg;
   logic [4:0]     strobe_sync_out;
   logic           mreq_s, iorq_s, rd_s, wr_s, rfsh_s;
   logic           qualify, rd_req, wr_req;
   logic [SRAM_AW-1:0] addr_next;

   strobe_sync #(.STAGES(SYNC_STAGES), .WIDTH(5)) u_strobe_sync (
      .clk   (clk_vram),
      .reset (reset),
      .din   ({nRFSH, nWR, nRD, nIORQ, nMREQ}),
      .dout  (strobe_sync_out)
   );

   assign {rfsh_s, wr_s, rd_s, iorq_s, mreq_s} = strobe_sync_out;

   // A is stable by the time the synchronised strobes qualify.
   assign qualify = !mreq_s && iorq_s && rfsh_s && (A >= EXT_RAM_BASE);
   assign rd_req  = qualify && !rd_s &&  wr_s;
   assign wr_req  = qualify &&  rd_s && !wr_s;
   assign addr_next = {{(SRAM_AW-15){1'b0}}, A[14:0]};

   // Only the low byte lane is used; lane enables are fixed.
   assign sram_lb_n = 1'b0;
   assign sram_ub_n = 1'b1;
   assign busy      = (state_reg != ST_IDLE);

   // Access sequencer; strobes are registered and set on entry to each state.
   always_ff @(posedge clk_vram) begin
      if (reset) begin
         state_reg   <= ST_IDLE;
         cnt_reg     <= '0;
         ram_data    <= RAM_FILL;
         nwait       <= 1'b1;
         sram_ce_n   <= 1'b1;
         sram_oe_n   <= 1'b1;
         sram_we_n   <= 1'b1;
         sram_dq_oe  <= 1'b0;
         sram_addr   <= '0;
         sram_dq_out <= '0;
      end else begin
         case (state_reg)
            ST_IDLE: begin
               if (rd_req) begin
                  sram_addr <= addr_next;
                  sram_ce_n <= 1'b0;
                  sram_oe_n <= 1'b0;
                  nwait     <= 1'b0;
                  state_reg <= ST_RD_SETUP;
               end else if (wr_req) begin
                  sram_addr   <= addr_next;
                  sram_dq_out <= D_in;
                  sram_ce_n   <= 1'b0;
                  sram_dq_oe  <= 1'b1;
                  nwait       <= 1'b0;
                  state_reg   <= ST_WR_SETUP;
               end
            end
            ST_RD_SETUP: begin
               cnt_reg   <= CNT_LOAD;
               state_reg <= ST_RD_WAIT;
            end
            ST_RD_WAIT: begin
               if (cnt_reg == 4'd0) begin
                  ram_data  <= sram_dq_in;
                  sram_ce_n <= 1'b1;
                  sram_oe_n <= 1'b1;
                  nwait     <= 1'b1;
                  state_reg <= ST_RELEASE;
               end else begin
                  cnt_reg <= cnt_reg - 4'd1;
               end
            end
            ST_WR_SETUP: begin
               sram_we_n <= 1'b0;
               cnt_reg   <= CNT_LOAD;
               state_reg <= ST_WR_PULSE;
            end
            ST_WR_PULSE: begin
               if (cnt_reg == 4'd0) begin
                  sram_we_n <= 1'b1;
                  state_reg <= ST_WR_HOLD;
               end else begin
                  cnt_reg <= cnt_reg - 4'd1;
               end
            end
            ST_WR_HOLD: begin
               sram_dq_oe <= 1'b0;
               sram_ce_n  <= 1'b1;
               nwait      <= 1'b1;
               state_reg  <= ST_RELEASE;
            end
            ST_RELEASE: begin
               // Wait for the CPU cycle to end so a held strobe cannot retrigger.
               if (mreq_s || (rd_s && wr_s)) state_reg <= ST_IDLE;
            end
            default: state_reg <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_ext_ram_bridge.sv
// Self-checking bench for ext_ram_bridge: directed scenarios followed by
// randomised CPU cycles checked against a transaction-level memory model.
module tb_ext_ram_bridge;

   localparam int AW = 18;

   logic          clk_vram = 1'b0;
   logic          reset;
   logic [15:0]   A;
   logic [7:0]    D_in;
   logic          nMREQ, nIORQ, nRD, nWR, nRFSH;
   logic [7:0]    ram_data;
   logic          nwait, busy;
   logic [AW-1:0] sram_addr;
   logic [7:0]    sram_dq_out;
   logic          sram_dq_oe;
   logic [7:0]    sram_dq_in;
   logic          sram_ce_n, sram_oe_n, sram_we_n, sram_lb_n, sram_ub_n;

   ext_ram_bridge dut (
      .clk_vram    (clk_vram),
      .reset       (reset),
      .A           (A),
      .D_in        (D_in),
      .nMREQ       (nMREQ),
      .nIORQ       (nIORQ),
      .nRD         (nRD),
      .nWR         (nWR),
      .nRFSH       (nRFSH),
      .ram_data    (ram_data),
      .nwait       (nwait),
      .busy        (busy),
      .sram_addr   (sram_addr),
      .sram_dq_out (sram_dq_out),
      .sram_dq_oe  (sram_dq_oe),
      .sram_dq_in  (sram_dq_in),
      .sram_ce_n   (sram_ce_n),
      .sram_oe_n   (sram_oe_n),
      .sram_we_n   (sram_we_n),
      .sram_lb_n   (sram_lb_n),
      .sram_ub_n   (sram_ub_n)
   );

   always #5 clk_vram = ~clk_vram;

   int checks   = 0;
   int failures = 0;

   // SRAM device model and bus monitor
   logic [7:0]    dev_mem [0:(1<<AW)-1];
   logic [AW-1:0] dev_last_addr;
   logic [7:0]    dev_last_data;
   int rd_acc = 0, wr_acc = 0, ce_low = 0, oe_low = 0, we_low = 0;
   int nwait_low = 0, busy_cyc = 0, viol = 0;
   logic prev_oe = 1'b1, prev_we = 1'b1;

   assign sram_dq_in = (!sram_ce_n && !sram_oe_n) ? dev_mem[sram_addr] : 8'h00;

   always @(negedge clk_vram) begin
      if (!sram_ce_n) ce_low++;
      if (!sram_oe_n) oe_low++;
      if (!sram_we_n) we_low++;
      if (!nwait)     nwait_low++;
      if (busy)       busy_cyc++;
      if (prev_oe && !sram_oe_n) rd_acc++;
      if (!prev_we && sram_we_n) begin
         wr_acc++;
         dev_mem[sram_addr] = sram_dq_out;
         dev_last_addr = sram_addr;
         dev_last_data = sram_dq_out;
      end
      if (!sram_oe_n && !sram_we_n) viol++;
      if (sram_dq_oe && !sram_oe_n) viol++;
      if (!sram_we_n && (!sram_dq_oe || sram_ce_n)) viol++;
      prev_oe = sram_oe_n;
      prev_we = sram_we_n;
   end

   // Reference model: CPU-visible contents of the upper 32K and last read byte
   logic [7:0] ref_mem [0:32767];
   logic [7:0] ref_ram_data;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic idle_bus();
      nMREQ = 1'b1; nIORQ = 1'b1; nRD = 1'b1; nWR = 1'b1; nRFSH = 1'b1;
   endtask

   // One CPU cycle: strobes held 'hold' clocks, then released and settled.
   task automatic cpu_cycle(input string tag, input logic [15:0] a, input logic [7:0] d,
                            input bit rd, input bit wr, input bit io, input bit rfsh,
                            input int hold);
      bit   qual, exp_rd, exp_wr;
      int   rd0, wr0, ce0, oe0, we0, nw0, bz0;
      logic [7:0] old_data, new_data;
      qual   = !io && !rfsh && a[15];
      exp_rd = qual && rd && !wr;
      exp_wr = qual && wr && !rd;
      rd0 = rd_acc; wr0 = wr_acc; ce0 = ce_low; oe0 = oe_low;
      we0 = we_low; nw0 = nwait_low; bz0 = busy_cyc;
      old_data = ref_ram_data;
      new_data = exp_rd ? ref_mem[a[14:0]] : ref_ram_data;
      @(posedge clk_vram); #1;
      A = a; D_in = d;
      nMREQ = io ? 1'b1 : 1'b0;
      nIORQ = io ? 1'b0 : 1'b1;
      nRFSH = rfsh ? 1'b0 : 1'b1;
      nRD = !rd; nWR = !wr;
      for (int i = 1; i <= hold; i++) begin
         @(posedge clk_vram); #1;
         if (exp_rd && i == 5) check({tag, " data_before"}, {24'h0, ram_data}, {24'h0, old_data});
         if (exp_rd && i == 6) check({tag, " data_latency"}, {24'h0, ram_data}, {24'h0, new_data});
         if (i == hold - 1 && qual && (rd ^ wr)) check({tag, " busy_held"}, {31'h0, busy}, 32'h1);
      end
      idle_bus();
      repeat (6) @(posedge clk_vram);
      #1;
      if (exp_wr) ref_mem[a[14:0]] = d;
      ref_ram_data = new_data;
      check({tag, " reads"},  rd_acc - rd0, {31'h0, exp_rd});
      check({tag, " writes"}, wr_acc - wr0, {31'h0, exp_wr});
      check({tag, " ram_data"}, {24'h0, ram_data}, {24'h0, ref_ram_data});
      check({tag, " busy_end"}, {31'h0, busy}, 32'h0);
      if (exp_rd) begin
         check({tag, " oe_low"},    oe_low - oe0,    32'd3);
         check({tag, " nwait_low"}, nwait_low - nw0, 32'd3);
      end
      if (exp_wr) begin
         check({tag, " we_low"},    we_low - we0,    32'd2);
         check({tag, " nwait_low"}, nwait_low - nw0, 32'd4);
         check({tag, " wr_addr"},   32'(dev_last_addr), {17'h0, a[14:0]});
         check({tag, " wr_data"},   {24'h0, dev_last_data}, {24'h0, d});
      end
      if (!qual || !(rd ^ wr)) begin
         check({tag, " ce_quiet"},   ce_low - ce0,   32'd0);
         check({tag, " busy_quiet"}, busy_cyc - bz0, 32'd0);
      end
   endtask

   initial begin
      int kind, hold;
      logic [15:0] a;
      logic [7:0]  d;
      for (int i = 0; i < (1 << AW); i++) dev_mem[i] = 8'h00;
      for (int i = 0; i < 32768; i++) ref_mem[i] = 8'h00;
      ref_ram_data = 8'hFF;
      A = 16'h0; D_in = 8'h0;
      idle_bus();
      reset = 1'b1;
      repeat (3) @(posedge clk_vram);
      #1;
      reset = 1'b0;
      check("rst ram_data", {24'h0, ram_data}, 32'hFF);
      check("rst nwait", {31'h0, nwait}, 32'h1);
      check("rst busy", {31'h0, busy}, 32'h0);
      check("rst strobes", {29'h0, sram_ce_n, sram_oe_n, sram_we_n}, 32'h7);
      check("rst dq_oe", {31'h0, sram_dq_oe}, 32'h0);
      check("rst addr", 32'(sram_addr), 32'h0);
      check("rst dq_out", {24'h0, sram_dq_out}, 32'h0);
      check("rst lanes", {30'h0, sram_lb_n, sram_ub_n}, 32'h1);

      cpu_cycle("wr8123", 16'h8123, 8'h5A, 1'b0, 1'b1, 1'b0, 1'b0, 10);
      cpu_cycle("rd8123", 16'h8123, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 10);
      cpu_cycle("rd4000", 16'h4000, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 10);
      cpu_cycle("ioFE",   16'h00FE, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 10);
      cpu_cycle("wrC000", 16'hC000, 8'hA7, 1'b0, 1'b1, 1'b0, 1'b0, 10);
      cpu_cycle("rdhold", 16'hC000, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 40);
      cpu_cycle("rfsh",   16'hFF00, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 10);
      cpu_cycle("illegal",16'h9000, 8'h33, 1'b1, 1'b1, 1'b0, 1'b0, 10);

      // Reset asserted while the read is in its wait phase
      @(posedge clk_vram); #1;
      A = 16'h8123; nMREQ = 1'b0; nRD = 1'b0;
      repeat (4) @(posedge clk_vram);
      #1;
      check("midrd oe_active", {31'h0, sram_oe_n}, 32'h0);
      reset = 1'b1;
      @(posedge clk_vram); #1;
      check("midrd strobes", {29'h0, sram_ce_n, sram_oe_n, sram_we_n}, 32'h7);
      check("midrd dq_oe", {31'h0, sram_dq_oe}, 32'h0);
      check("midrd nwait", {31'h0, nwait}, 32'h1);
      check("midrd ram_data", {24'h0, ram_data}, 32'hFF);
      check("midrd busy", {31'h0, busy}, 32'h0);
      idle_bus();
      repeat (2) @(posedge clk_vram);
      #1;
      reset = 1'b0;
      ref_ram_data = 8'hFF;
      repeat (3) @(posedge clk_vram);

      for (int t = 0; t < 40; t++) begin
         kind = $urandom_range(0, 5);
         hold = $urandom_range(8, 12);
         d    = 8'($urandom);
         a    = {1'b1, 15'($urandom_range(0, 7) * 1031)};
         case (kind)
            0: cpu_cycle("rnd_rd", a, d, 1'b1, 1'b0, 1'b0, 1'b0, hold);
            1: cpu_cycle("rnd_wr", a, d, 1'b0, 1'b1, 1'b0, 1'b0, hold);
            2: cpu_cycle("rnd_lo", {1'b0, a[14:0]}, d, 1'b1, 1'b0, 1'b0, 1'b0, hold);
            3: cpu_cycle("rnd_io", a, d, 1'b0, 1'b1, 1'b1, 1'b0, hold);
            4: cpu_cycle("rnd_rf", a, d, 1'b1, 1'b0, 1'b0, 1'b1, hold);
            default: cpu_cycle("rnd_il", a, d, 1'b1, 1'b1, 1'b0, 1'b0, hold);
         endcase
      end

      check("protocol_violations", viol, 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
